// File: rtl/pulse_shaper_mc.sv
// Multi-channel delayed-pulse shaper.
// Each channel waits DELAY enabled edges after a trigger on x, then drives z
// high for at least MIN_W enabled edges. After that z either follows x (hold
// mode) or drops and waits for x to go low (one-shot mode). The mode is
// captured per channel at trigger time, so later mode changes only affect
// channels that have not yet triggered. A shared enable freezes every channel.
module pulse_shaper_mc #(
   parameter int CH    = 4,
   parameter int DELAY = 2,
   parameter int MIN_W = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          allow,
   input  logic          mode,
   input  logic [CH-1:0] x,
   output logic [CH-1:0] z,
   output logic [CH-1:0] busy
);

   localparam int MAX_DM = (DELAY > MIN_W) ? DELAY : MIN_W;
   localparam int CNT_W  = $clog2(MAX_DM + 1);

   // Reload values: the counter counts the remaining edges down to 0.
   localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY - 1);
   localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(MIN_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      DLY,
      ACT,
      CHK,
      WLOW
   } state_t;

   // A zero delay or zero width has no meaningful timing, so refuse to build.
   generate
      if (DELAY < 1) begin : g_bad_delay
         $error("pulse_shaper_mc: DELAY must be 1 or more");
      end
      if (MIN_W < 1) begin : g_bad_min_w
         $error("pulse_shaper_mc: MIN_W must be 1 or more");
      end
   endgenerate

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         state_t           state;
         state_t           state_n;
         logic [CNT_W-1:0] cnt;
         logic [CNT_W-1:0] cnt_n;
         logic             mode_l;
         logic             mode_l_n;
         logic             z_q;
         logic             z_n;
         logic             busy_q;

         // State, counter, latched mode and registered outputs; frozen while allow is low.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state  <= IDLE;
               cnt    <= '0;
               mode_l <= 1'b0;
               z_q    <= 1'b0;
               busy_q <= 1'b0;
            end else if (allow) begin
               state  <= state_n;
               cnt    <= cnt_n;
               mode_l <= mode_l_n;
               z_q    <= z_n;
               busy_q <= (state_n != IDLE);
            end
         end

         // Next-state and next-output logic; the last ACT edge applies the
         // release decision directly so z can drop right after MIN_W edges.
         always_comb begin
            state_n  = state;
            cnt_n    = cnt;
            mode_l_n = mode_l;
            z_n      = 1'b0;
            case (state)
               IDLE: begin
                  if (x[i]) begin
                     state_n  = DLY;
                     cnt_n    = DLY_LOAD;
                     mode_l_n = mode;
                  end
               end
               DLY: begin
                  if (cnt == '0) begin
                     state_n = ACT;
                     cnt_n   = ACT_LOAD;
                     z_n     = 1'b1;
                  end else begin
                     cnt_n = cnt - CNT_ONE;
                  end
               end
               ACT, CHK: begin
                  if (state == ACT && cnt != '0) begin
                     cnt_n = cnt - CNT_ONE;
                     z_n   = 1'b1;
                  end else if (x[i] && !mode_l) begin
                     state_n = CHK;
                     z_n     = 1'b1;
                  end else if (x[i]) begin
                     state_n = WLOW;
                  end else begin
                     state_n = IDLE;
                  end
               end
               WLOW: begin
                  if (!x[i]) begin
                     state_n = IDLE;
                  end
               end
               default: begin
                  state_n = IDLE;
               end
            endcase
         end

         assign z[i]    = z_q;
         assign busy[i] = busy_q;
      end
   endgenerate

endmodule

// File: tb/tb_pulse_shaper_mc.sv
// Directed bench for pulse_shaper_mc with default parameters.
// Edge e=0 is the enabled edge that samples the trigger; outputs are read
// 1 time unit after each rising edge and compared with hand-derived tables.
module tb_pulse_shaper_mc;

   logic       clk;
   logic       rst_n;
   logic       allow;
   logic       mode;
   logic [3:0] x;
   logic [3:0] z;
   logic [3:0] busy;

   int n_cmp;
   int n_bad;

   pulse_shaper_mc #(
      .CH   (4),
      .DELAY(2),
      .MIN_W(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .allow(allow),
      .mode (mode),
      .x    (x),
      .z    (z),
      .busy (busy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      x = 4'b0000;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      allow = 1'b1;
      mode  = 1'b0;
      x     = 4'b1111;
      tick();
      tick();
      n_cmp++;
      if (z !== 4'b0000) begin
         n_bad++;
         $display("[TB] FAIL reset_z got %b want %b", z, 4'b0000);
      end
      n_cmp++;
      if (busy !== 4'b0000) begin
         n_bad++;
         $display("[TB] FAIL reset_busy got %b want %b", busy, 4'b0000);
      end
      x = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_hold();
      logic [7:0] exp_z;
      logic [7:0] exp_b;
      exp_z = 8'b0011_1100;
      exp_b = 8'b0011_1111;
      mode  = 1'b0;
      x     = 4'b0001;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_cmp++;
         if (z[0] !== exp_z[e]) begin
            n_bad++;
            $display("[TB] FAIL hold_z0 e=%0d got %b want %b", e, z[0], exp_z[e]);
         end
         n_cmp++;
         if (busy[0] !== exp_b[e]) begin
            n_bad++;
            $display("[TB] FAIL hold_busy0 e=%0d got %b want %b", e, busy[0], exp_b[e]);
         end
         if (e == 5) x[0] = 1'b0;
      end
      settle(2);
   endtask

   task automatic test_short_trigger();
      logic [11:0] exp_z;
      logic [11:0] exp_b;
      exp_z = 12'b0001_1000_1100;
      exp_b = 12'b0001_1110_1111;
      mode  = 1'b0;
      x     = 4'b0010;
      for (int e = 0; e < 12; e++) begin
         tick();
         n_cmp++;
         if (z[1] !== exp_z[e]) begin
            n_bad++;
            $display("[TB] FAIL short_z1 e=%0d got %b want %b", e, z[1], exp_z[e]);
         end
         n_cmp++;
         if (busy[1] !== exp_b[e]) begin
            n_bad++;
            $display("[TB] FAIL short_busy1 e=%0d got %b want %b", e, busy[1], exp_b[e]);
         end
         x[1] = (e == 4);
      end
      settle(2);
   endtask

   task automatic test_enable_gating();
      logic [8:0] exp_z;
      logic [8:0] exp_b;
      exp_z = 9'b0_0110_0000;
      exp_b = 9'b0_0111_1111;
      mode  = 1'b0;
      x     = 4'b0001;
      for (int e = 0; e < 9; e++) begin
         tick();
         n_cmp++;
         if (z[0] !== exp_z[e]) begin
            n_bad++;
            $display("[TB] FAIL gate_z0 e=%0d got %b want %b", e, z[0], exp_z[e]);
         end
         n_cmp++;
         if (busy[0] !== exp_b[e]) begin
            n_bad++;
            $display("[TB] FAIL gate_busy0 e=%0d got %b want %b", e, busy[0], exp_b[e]);
         end
         n_cmp++;
         if ({z[1], busy[1]} !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL gate_ch1 e=%0d got %b want %b", e, {z[1], busy[1]}, 2'b00);
         end
         if (e >= 1 && e <= 3) begin
            allow = 1'b0;
            x     = (e == 2) ? 4'b0000 : 4'b0011;
         end else begin
            allow = 1'b1;
            x     = 4'b0000;
         end
      end
      allow = 1'b1;
      settle(2);
   endtask

   task automatic test_one_shot();
      logic [15:0] exp_z;
      logic [15:0] exp_b;
      exp_z = 16'b0110_0000_0000_1100;
      exp_b = 16'b1111_1011_1111_1111;
      mode  = 1'b1;
      x     = 4'b0100;
      for (int e = 0; e < 16; e++) begin
         tick();
         n_cmp++;
         if (z[2] !== exp_z[e]) begin
            n_bad++;
            $display("[TB] FAIL oneshot_z2 e=%0d got %b want %b", e, z[2], exp_z[e]);
         end
         n_cmp++;
         if (busy[2] !== exp_b[e]) begin
            n_bad++;
            $display("[TB] FAIL oneshot_busy2 e=%0d got %b want %b", e, busy[2], exp_b[e]);
         end
         x[2] = (e < 9) || (e >= 10);
      end
      settle(3);
      mode = 1'b0;
   endtask

   task automatic test_independence();
      logic [9:0] exp_z0;
      logic [9:0] exp_b0;
      logic [9:0] exp_z3;
      logic [9:0] exp_b3;
      exp_z0 = 10'b00_1111_1100;
      exp_b0 = 10'b00_1111_1111;
      exp_z3 = 10'b00_0001_1000;
      exp_b3 = 10'b00_1111_1110;
      mode   = 1'b0;
      x      = 4'b0001;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_cmp++;
         if (z[0] !== exp_z0[e]) begin
            n_bad++;
            $display("[TB] FAIL indep_z0 e=%0d got %b want %b", e, z[0], exp_z0[e]);
         end
         n_cmp++;
         if (busy[0] !== exp_b0[e]) begin
            n_bad++;
            $display("[TB] FAIL indep_busy0 e=%0d got %b want %b", e, busy[0], exp_b0[e]);
         end
         n_cmp++;
         if (z[3] !== exp_z3[e]) begin
            n_bad++;
            $display("[TB] FAIL indep_z3 e=%0d got %b want %b", e, z[3], exp_z3[e]);
         end
         n_cmp++;
         if (busy[3] !== exp_b3[e]) begin
            n_bad++;
            $display("[TB] FAIL indep_busy3 e=%0d got %b want %b", e, busy[3], exp_b3[e]);
         end
         mode = 1'b1;
         x    = (e < 7) ? 4'b1001 : 4'b0000;
      end
      settle(2);
      mode = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [4:0] exp_z;
      logic [4:0] exp_b;
      exp_z = 5'b0_1100;
      exp_b = 5'b0_1111;
      mode  = 1'b0;
      x     = 4'b0001;
      tick();
      x = 4'b0000;
      tick();
      tick();
      n_cmp++;
      if (z[0] !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL areset_pre_z0 got %b want %b", z[0], 1'b1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (z !== 4'b0000) begin
         n_bad++;
         $display("[TB] FAIL areset_z got %b want %b", z, 4'b0000);
      end
      n_cmp++;
      if (busy !== 4'b0000) begin
         n_bad++;
         $display("[TB] FAIL areset_busy got %b want %b", busy, 4'b0000);
      end
      #2;
      rst_n = 1'b1;
      x     = 4'b0001;
      for (int e = 0; e < 5; e++) begin
         tick();
         x = 4'b0000;
         n_cmp++;
         if (z[0] !== exp_z[e]) begin
            n_bad++;
            $display("[TB] FAIL areset_z0 e=%0d got %b want %b", e, z[0], exp_z[e]);
         end
         n_cmp++;
         if (busy !== {3'b000, exp_b[e]}) begin
            n_bad++;
            $display("[TB] FAIL areset_busy e=%0d got %b want %b", e, busy, {3'b000, exp_b[e]});
         end
      end
   endtask

   // Run all scenarios in order and report the totals.
   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      allow = 1'b1;
      mode  = 1'b0;
      x     = 4'b0000;
      test_reset();
      test_hold();
      test_short_trigger();
      test_enable_gating();
      test_one_shot();
      test_independence();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
